// File: rtl/fft_pkg.sv
// Shared definitions for the FFT butterflies: default widths, butterfly FSM
// state encoding and the Q-format product truncation.
package fft_pkg;

    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_FACTOR_WIDTH = 16;
    localparam int DEF_FRAC_BITS    = 14;
    localparam int DEF_PROD_WIDTH   = DEF_DATA_WIDTH + DEF_FACTOR_WIDTH;

    // ST_A: idle or finishing the cross products; ST_B: straight products.
    typedef enum logic {
        ST_A = 1'b0,
        ST_B = 1'b1
    } bfly_state_t;

    // Drop the twiddle fraction bits (floor) and keep DATA_WIDTH bits.
    function automatic logic signed [DEF_DATA_WIDTH-1:0] q_trunc(
        input logic signed [DEF_PROD_WIDTH-1:0] prod
    );
        return prod[DEF_DATA_WIDTH+DEF_FRAC_BITS-1:DEF_FRAC_BITS];
    endfunction

endpackage

// File: rtl/fixed_mult_trunc.sv
// Combinational signed data x twiddle multiply, truncated back to data width.
module fixed_mult_trunc
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int FACTOR_WIDTH = DEF_FACTOR_WIDTH,
    parameter int FRAC_BITS    = DEF_FRAC_BITS
) (
    input  logic signed [DATA_WIDTH-1:0]   d,
    input  logic signed [FACTOR_WIDTH-1:0] w,
    output logic signed [DATA_WIDTH-1:0]   y
);

    localparam int PROD_WIDTH = DATA_WIDTH + FACTOR_WIDTH;

    logic signed [PROD_WIDTH-1:0] prod;

    assign prod = d * w;

    // Default widths go through the shared helper; other widths slice directly.
    generate
        if (DATA_WIDTH == DEF_DATA_WIDTH && FACTOR_WIDTH == DEF_FACTOR_WIDTH &&
            FRAC_BITS == DEF_FRAC_BITS) begin : g_pkg_trunc
            assign y = q_trunc(prod);
        end else begin : g_slice_trunc
            assign y = prod[DATA_WIDTH+FRAC_BITS-1:FRAC_BITS];
        end
    endgenerate

endmodule

// File: rtl/butterfly_dif.sv
// Radix-2 DIF butterfly: y0 = x0 + x1, y1 = (x0 - x1) * w.
// Two shared multipliers do the complex multiply over two cycles, so one
// butterfly is accepted every other cycle; results pulse out_valid once.
module butterfly_dif
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int FACTOR_WIDTH = DEF_FACTOR_WIDTH,
    parameter int FRAC_BITS    = DEF_FRAC_BITS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2*DATA_WIDTH-1:0]   in_x0,
    input  logic [2*DATA_WIDTH-1:0]   in_x1,
    input  logic [2*FACTOR_WIDTH-1:0] w,
    output logic                      out_valid,
    output logic [2*DATA_WIDTH-1:0]   out_x0,
    output logic [2*DATA_WIDTH-1:0]   out_x1
);

    bfly_state_t state;
    logic        cross_pend;
    logic        accept;
    logic        cross_sel;

    logic signed [DATA_WIDTH-1:0]   x0_r, x0_i, x1_r, x1_i;
    logic signed [DATA_WIDTH-1:0]   s_r, s_i, d_r, d_i;
    logic signed [FACTOR_WIDTH-1:0] w_r, w_i;
    logic signed [DATA_WIDTH-1:0]   p_rr, p_ii;
    logic [2*DATA_WIDTH-1:0]        s_d;

    // Multiplier 0 always takes d_r, multiplier 1 always takes d_i; only the
    // twiddle component swaps between the straight and cross phases.
    logic signed [DATA_WIDTH-1:0]   mul_d [2];
    logic signed [FACTOR_WIDTH-1:0] mul_w [2];
    logic signed [DATA_WIDTH-1:0]   mul_y [2];

    assign x0_r = in_x0[2*DATA_WIDTH-1:DATA_WIDTH];
    assign x0_i = in_x0[DATA_WIDTH-1:0];
    assign x1_r = in_x1[2*DATA_WIDTH-1:DATA_WIDTH];
    assign x1_i = in_x1[DATA_WIDTH-1:0];

    assign in_ready  = (state == ST_A);
    assign accept    = in_valid && in_ready;
    assign cross_sel = (state == ST_A) && cross_pend;

    assign mul_d[0] = d_r;
    assign mul_d[1] = d_i;
    assign mul_w[0] = cross_sel ? w_i : w_r;
    assign mul_w[1] = cross_sel ? w_r : w_i;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_mult
            fixed_mult_trunc #(
                .DATA_WIDTH  (DATA_WIDTH),
                .FACTOR_WIDTH(FACTOR_WIDTH),
                .FRAC_BITS   (FRAC_BITS)
            ) u_mult (
                .d(mul_d[gi]),
                .w(mul_w[gi]),
                .y(mul_y[gi])
            );
        end
    endgenerate

    // FSM plus datapath: load operands on accept, latch straight products in
    // ST_B, and emit the result while finishing the cross products in ST_A.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_A;
            cross_pend <= 1'b0;
            s_r        <= '0;
            s_i        <= '0;
            d_r        <= '0;
            d_i        <= '0;
            w_r        <= '0;
            w_i        <= '0;
            p_rr       <= '0;
            p_ii       <= '0;
            s_d        <= '0;
            out_valid  <= 1'b0;
            out_x0     <= '0;
            out_x1     <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_A: begin
                    if (cross_pend) begin
                        out_x1     <= {p_rr - p_ii, mul_y[0] + mul_y[1]};
                        out_x0     <= s_d;
                        out_valid  <= 1'b1;
                        cross_pend <= 1'b0;
                    end
                    if (accept) begin
                        s_r   <= x0_r + x1_r;
                        s_i   <= x0_i + x1_i;
                        d_r   <= x0_r - x1_r;
                        d_i   <= x0_i - x1_i;
                        w_r   <= w[2*FACTOR_WIDTH-1:FACTOR_WIDTH];
                        w_i   <= w[FACTOR_WIDTH-1:0];
                        state <= ST_B;
                    end
                end
                ST_B: begin
                    p_rr       <= mul_y[0];
                    p_ii       <= mul_y[1];
                    s_d        <= {s_r, s_i};
                    cross_pend <= 1'b1;
                    state      <= ST_A;
                end
                default: state <= ST_A;
            endcase
        end
    end

endmodule

// File: doc/butterfly_dif.md
# butterfly_dif

Radix-2 decimation-in-frequency butterfly: the inverse-direction counterpart of the DIT butterfly in the shared-butterfly FFT, used for DIF forward stages and for the IFFT path.
- y0 = x0 + x1
- y1 = (x0 − x1)·w

The complex multiply runs on two shared signed multipliers over two cycles, so the block accepts at most one butterfly every 2 cycles. It sits between the stage memory read port and the write-back port, with a valid/ready input handshake and a valid-only output.

## Interface
- DATA_WIDTH, 32, width of each real/imag data component (signed two's complement)
- FACTOR_WIDTH, 16, width of each twiddle component (signed Q(FACTOR_WIDTH−FRAC_BITS).FRAC_BITS)
- FRAC_BITS, 14, twiddle fractional bits (1.0 = 16384 at default)
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  input operands valid
- in_ready  out  1  block can accept this cycle
- in_x0  in  2*DATA_WIDTH  {real, imag}
- in_x1  in  2*DATA_WIDTH  {real, imag}
- w  in  2*FACTOR_WIDTH  twiddle {real, imag}; sampled with x0/x1
- out_valid  out  1  one-cycle pulse, results valid
- out_x0  out  2*DATA_WIDTH  y0 {real, imag}; held until next result
- out_x1  out  2*DATA_WIDTH  y1 {real, imag}; held until next result

## Operation
- FSM with two states:
  - ST_A: in_ready=1.
  - ST_B: in_ready=0.
  - ST_A→ST_B on accept (in_valid && in_ready).
  - ST_B→ST_A unconditionally.
  - ST_A with no accept stays in ST_A.
- Accept edge E0 registers:
  - s = x0 + x1 and d = x0 − x1, per component, DATA_WIDTH wrap, no saturation.
  - w_r, w_i.
- Cycle after E0 (ST_B): multipliers compute d_r·w_r and d_i·w_i. Edge E1 registers both as truncated products p_rr and p_ii, sets cross_pend=1, and copies s to s_d.
- Cycle after E1 (ST_A, cross_pend=1): multipliers compute d_r·w_i and d_i·w_r. Edge E2 registers:
  - out_x1 = {p_rr − p_ii, trunc(d_r·w_i) + trunc(d_i·w_r)}
  - out_x0 = s_d
  - out_valid=1
  - cross_pend=0
- A new accept at E2 is legal: stage-0 registers reload while the edge reads the old values.
- Multiplier operand mux is selected by state/cross_pend only. Idle cycles drive the straight-product operands and the results are ignored.
- Product width is DATA_WIDTH+FACTOR_WIDTH, full signed. Truncation takes bits [DATA_WIDTH+FRAC_BITS−1 : FRAC_BITS], which is floor (round toward −∞). Final add/sub wrap at DATA_WIDTH.
- No output backpressure: the consumer must take results on the out_valid pulse.

## Timing
- Latency: accept at E0 → out_valid high for exactly one cycle after E2 (2 cycles).
- Throughput: 1 butterfly / 2 cycles. With in_valid held high, in_ready toggles 1,0,1,0.
- in_valid while in_ready=0 is ignored; the source holds its data.
- Reset (rst low, async): all outputs and registers are 0.
  - out_valid=0, out_x0=0, out_x1=0.
  - State ST_A, cross_pend=0.
  - in_ready is decoded from state, so it reads 1, but no accept occurs while rst is low.
- Reset mid-operation (between E0 and E2): the in-flight butterfly is discarded, no out_valid pulse follows, and outputs stay 0.
- Release of rst: the first edge with rst high may accept.

## Structure
- The shared package fft_pkg holds:
  - default DATA_WIDTH/FACTOR_WIDTH/FRAC_BITS
  - FSM state encoding (ST_A, ST_B)
  - Q-format truncation function (product → DATA_WIDTH slice)
- Sub-module fixed_mult_trunc: combinational signed DATA_WIDTH×FACTOR_WIDTH multiply plus FRAC_BITS slice. It is instantiated twice, and the same module is reusable by butterfly_dit.

## Test plan
- Unity twiddle: x0=(100,50), x1=(20,10), w=(16384,0), accept → 2 cycles later out_valid=1, out_x0=(120,60), out_x1=(80,40).
- −j twiddle: x0=(10,0), x1=(0,10), w=(0,−16384) → out_x0=(10,10), out_x1=(−10,−10).
- Back-to-back with in_valid held high, two distinct operand sets:
  - in_ready sequence 1,0,1,0.
  - Two out_valid pulses spaced 2 cycles apart, each with the correct result.
  - No operand set lost or duplicated.
- Wrap: x0_r=0x7FFFFFFF, x1_r=1, others 0, w=(16384,0) → out_x0_r=0x80000000, out_x1_r=0x7FFFFFFE.
- Floor truncation: x0=(3,−3), x1=(0,0), w=(8192,0) → out_x1=(1,−2), out_x0=(3,−3).
- Reset mid-op: accept, then pull rst low one cycle later for 1 cycle → outputs immediately 0, no out_valid pulse, in_ready=1 with the FSM in ST_A, and the next accept produces a correct result.
